instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-address width of the instruction memory (depth 2**ADDR_W).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port clear  input  1  synchronous restart of a load session, same effect as reset.
REQ-005 SHALL have port in_valid  input  1  encode request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port in_kind  input  3  instruction class: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6-7 illegal.
REQ-008 SHALL have ports in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-009 SHALL have port in_funct  input  6  R-type funct field.
REQ-010 SHALL have port in_imm  input  16  immediate or branch offset.
REQ-011 SHALL have port in_target  input  26  jump target field.
REQ-012 SHALL have port wvalid  output  1  memory write pending.
REQ-013 SHALL have port wready  input  1  memory accepts write when wvalid && wready.
REQ-014 SHALL have port waddr  output  ADDR_W  word address of pending write.
REQ-015 SHALL have port wdata  output  32  encoded instruction word.
REQ-016 SHALL have port count  output  ADDR_W+1  words written this session.
REQ-017 SHALL have port full  output  1  memory fully loaded; no further requests accepted.
REQ-018 SHALL have port err  output  1  sticky, illegal in_kind seen this session.

Function
REQ-019 SHALL encode RTYPE as {000000, rs, rt, rd, 00000, funct}.
REQ-020 SHALL encode LW {100011, rs, rt, imm}, SW {101011, rs, rt, imm}, BEQ {000100, rs, rt, imm}, ADDI {001000, rs, rt, imm}.
REQ-021 SHALL encode J as {000010, target}.
REQ-022 SHALL use one output register stage: accepted legal request appears on wvalid/wdata/waddr the next cycle; latency 1 cycle.
REQ-023 SHALL drive in_ready = !full && (!wvalid || wready) (combinational, no skid buffer).
REQ-024 SHALL hold wvalid, waddr, wdata stable while wvalid && !wready.
REQ-025 SHALL, on accepted illegal kind, set err, emit no write, leave address and count unchanged.
REQ-026 SHALL keep a write pointer, starting at 0, assigned to waddr on accept and incremented by 1 per accepted legal request.
REQ-027 SHALL increment count on each completed write (wvalid && wready), saturating at 2**ADDR_W.
REQ-028 SHALL run a two-state FSM: LOAD (accepting) -> FULL when the legal request occupying address 2**ADDR_W-1 is accepted; FULL held until reset/clear; no pointer wrap-around.
REQ-029 SHALL assert full in FULL state; the final pending write still completes normally.
REQ-030 SHALL, on simultaneous write completion and new accept, load the new word in the same cycle without bubble.
REQ-031 SHALL give clear priority over in_valid and wready in the same cycle; pending write is discarded.

Reset
REQ-032 SHALL on reset or clear set: wvalid 0, waddr 0, wdata 0, count 0, full 0, err 0, pointer 0, FSM LOAD.
REQ-033 SHALL drop any pending or mid-handshake write when reset asserts; in_ready 1 the cycle after reset deasserts.

Structure
REQ-034 SHALL place in a shared package: in_kind codes, 6-bit opcode constants (000000, 100011, 101011, 000100, 001000, 000010), shared with the main decoder.
REQ-035 SHALL use one combinational sub-module instr_pack (kind + fields -> 32-bit word + legal flag); FSM, pointer and handshake stay in instr_encoder.

Verification
REQ-036 SHALL cover: RTYPE rs=1 rt=2 rd=3 funct=100000, wready=1 -> next cycle wvalid=1, waddr=0, wdata=0x00221820.
REQ-037 SHALL cover: LW rs=0 rt=2 imm=0x0050 then J target=0x0000011 back-to-back -> wdata 0x8C020050 @0, 0x08000011 @1, no bubble.
REQ-038 SHALL cover: wready=0 for 3 cycles with wvalid high -> in_ready=0, outputs stable; wready=1 -> write completes, count=1.
REQ-039 SHALL cover: kind=7 accepted -> err=1, no wvalid, pointer unchanged; next ADDI rs=0 rt=8 imm=5 -> 0x20080005 @0.
REQ-040 SHALL cover: ADDR_W=2, 5 legal requests -> four writes @0..3, full=1 after 4th accept, 5th held off, count=4.
REQ-041 SHALL cover: clear asserted with wvalid=1, wready=0 -> next cycle wvalid=0, count=0, err=0, next accept writes @0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared instruction-class codes, opcodes and encoder FSM states.
// The opcode constants are also used by the main decoder.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        KindRtype = 3'd0,
        KindLw    = 3'd1,
        KindSw    = 3'd2,
        KindBeq   = 3'd3,
        KindAddi  = 3'd4,
        KindJ     = 3'd5
    } kind_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef enum logic {
        StLoad,
        StFull
    } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Request and memory-write bundle for instr_encoder.
// The slave modport is the encoder side; the master modport is the requester/memory side.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              wvalid;
    logic              wready;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, wready,
        output in_ready, wvalid, waddr, wdata, count, full, err
    );

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, wready,
        input  in_ready, wvalid, waddr, wdata, count, full, err
    );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: instruction class plus fields to a 32-bit word.
// An unknown class yields a zero word with o_legal low.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_legal
);
    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        case (i_kind)
            KindRtype: o_word = {OpRtype, i_rs, i_rt, i_rd, 5'b00000, i_funct};
            KindLw:    o_word = {OpLw, i_rs, i_rt, i_imm};
            KindSw:    o_word = {OpSw, i_rs, i_rt, i_imm};
            KindBeq:   o_word = {OpBeq, i_rs, i_rt, i_imm};
            KindAddi:  o_word = {OpAddi, i_rs, i_rt, i_imm};
            KindJ:     o_word = {OpJ, i_target};
            default:   o_legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests and streams them into instruction memory, one word per
// address from 0 upward, stopping once the last address has been loaded.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input logic            clk,
    input logic            reset,
    input logic            clear,
    instr_encoder_if.slave bus
);
    localparam logic [ADDR_W:0]   CountMax = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PtrLast  = {ADDR_W{1'b1}};

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wvalid;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic              w_ready;
    logic              w_accept;
    logic              w_done;
    logic              w_legal;
    logic [31:0]       w_word;

    instr_pack u_pack (
        .i_kind   (bus.in_kind),
        .i_rs     (bus.in_rs),
        .i_rt     (bus.in_rt),
        .i_rd     (bus.in_rd),
        .i_funct  (bus.in_funct),
        .i_imm    (bus.in_imm),
        .i_target (bus.in_target),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    // The output register can take a new word in the same cycle the old one drains.
    assign w_ready  = (r_state == StLoad) && (!r_wvalid || bus.wready);
    assign w_accept = bus.in_valid && w_ready;
    assign w_done   = r_wvalid && bus.wready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StLoad: if (w_accept && w_legal && (r_ptr == PtrLast)) w_state_next = StFull;
            StFull: w_state_next = StFull;
            default: w_state_next = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) r_state <= StLoad;
        else                r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_ptr    <= '0;
            r_wvalid <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_done) begin
                r_wvalid <= 1'b0;
                if (r_count != CountMax) r_count <= r_count + 1'b1;
            end
            if (w_accept && w_legal) begin
                r_wvalid <= 1'b1;
                r_waddr  <= r_ptr;
                r_wdata  <= w_word;
                // Pointer parks on the last address; FULL blocks any further accepts.
                if (r_ptr != PtrLast) r_ptr <= r_ptr + 1'b1;
            end
            if (w_accept && !w_legal) r_err <= 1'b1;
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.wvalid   = r_wvalid;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
    assign bus.count    = r_count;
    assign bus.full     = (r_state == StFull);
    assign bus.err      = r_err;
endmodule
